// File: rtl/t64_wb_pkg.sv
// Shared types for the execute-to-writeback stage and the width extender.
package t64_wb_pkg;

  typedef enum logic [1:0] {
    W8  = 2'b00,
    W16 = 2'b01,
    W32 = 2'b10,
    W64 = 2'b11
  } width_t;

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'b000,
    BR_Z      = 3'b001,
    BR_NZ     = 3'b010,
    BR_C      = 3'b011,
    BR_NC     = 3'b100,
    BR_S      = 3'b101,
    BR_NS     = 3'b110,
    BR_NEVER  = 3'b111
  } br_cond_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_t;

  function automatic logic br_taken(input br_cond_t c, input logic z,
                                    input logic cy, input logic s);
    logic t;
    case (c)
      BR_ALWAYS: t = 1'b1;
      BR_Z:      t = z;
      BR_NZ:     t = ~z;
      BR_C:      t = cy;
      BR_NC:     t = ~cy;
      BR_S:      t = s;
      BR_NS:     t = ~s;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result input, register-file write port, redirect and bypass signals of the writeback stage.
interface alu_writeback_if #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] aluout;
  logic            zero;
  logic            carry;
  logic            setr;
  logic [1:0]      width;
  logic            sext;
  logic            wb_en;
  logic [RA_W-1:0] rd;
  logic            br_en;
  logic [2:0]      br_cond;
  logic [XLEN-1:0] br_target;
  logic            rf_we;
  logic            rf_ready;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            fwd_valid;
  logic [RA_W-1:0] fwd_addr;
  logic [XLEN-1:0] fwd_data;

  // The stage itself
  modport slave (
    input  in_valid, aluout, zero, carry, setr, width, sext, wb_en, rd,
           br_en, br_cond, br_target, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, redirect, redirect_pc,
           fwd_valid, fwd_addr, fwd_data
  );

  // Upstream ALU plus register file / fetch side
  modport master (
    output in_valid, aluout, zero, carry, setr, width, sext, wb_en, rd,
           br_en, br_cond, br_target, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, redirect, redirect_pc,
           fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/wb_extend.sv
// Combinational width mask with sign/zero extension (XLEN >= 32); shared with the load unit.
module wb_extend
  import t64_wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] din,
  input  width_t          width,
  input  logic            sext,
  output logic [XLEN-1:0] dout
);

  int   keep_bits;
  logic sign_bit;
  logic fill;

  always_comb begin
    keep_bits = XLEN;
    sign_bit  = din[XLEN-1];
    case (width)
      W8:  begin keep_bits = 8;  sign_bit = din[7];  end
      W16: begin keep_bits = 16; sign_bit = din[15]; end
      W32: begin keep_bits = 32; sign_bit = din[31]; end
      default: begin keep_bits = XLEN; sign_bit = din[XLEN-1]; end
    endcase
    fill = sext & sign_bit;
  end

  // Each bit either passes through or takes the fill value above the kept width
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
    assign dout[gi] = (gi < keep_bits) ? din[gi] : fill;
  end

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: extends ALU results, writes them back via a one-entry
// valid/ready buffer and resolves branches. Optional bypass outputs under WB_FORWARD_EN.
module alu_writeback
  import t64_wb_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_writeback_if.slave bus
);

  wb_state_t       state_reg, state_next;
  logic            alive_reg;
  logic            in_ready_c;
  logic            rf_we_c;
  logic            accept;
  logic            effective;
  logic            taken;
  logic [XLEN-1:0] ext_result;
  logic [RA_W-1:0] waddr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            redirect_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  wb_extend #(.XLEN(XLEN)) u_extend (
    .din  (bus.aluout),
    .width(width_t'(bus.width)),
    .sext (bus.sext),
    .dout (ext_result)
  );

  assign accept    = bus.in_valid && in_ready_c;
  assign effective = bus.wb_en && (bus.rd != '0);
  assign taken     = bus.br_en &&
                     br_taken(br_cond_t'(bus.br_cond), bus.zero, bus.carry, bus.setr);

  // alive_reg holds in_ready low until the first cycle after reset is released
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
      alive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      alive_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (accept && effective) state_next = FULL;
      FULL:  if (bus.rf_ready) state_next = (accept && effective) ? FULL : EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    rf_we_c    = 1'b0;
    case (state_reg)
      EMPTY: in_ready_c = alive_reg;
      FULL: begin
        rf_we_c    = 1'b1;
        in_ready_c = bus.rf_ready;
      end
      default: begin
        in_ready_c = 1'b0;
        rf_we_c    = 1'b0;
      end
    endcase
  end

  // Entry register only loads on an accepted effective write, so it stays stable while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else if (accept && effective) begin
      waddr_reg <= bus.rd;
      wdata_reg <= ext_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      redirect_reg    <= accept && taken;
      redirect_pc_reg <= (accept && taken) ? bus.br_target : '0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.rf_we       = rf_we_c;
  assign bus.rf_waddr    = waddr_reg;
  assign bus.rf_wdata    = wdata_reg;
  assign bus.redirect    = redirect_reg;
  assign bus.redirect_pc = redirect_pc_reg;

`ifdef WB_FORWARD_EN
  assign bus.fwd_valid = (state_reg == FULL);
  assign bus.fwd_addr  = waddr_reg;
  assign bus.fwd_data  = wdata_reg;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_addr  = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: vector tables, directed corner cases, random vs. queue model.
module tb_alu_writeback;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_writeback_if #(.XLEN(64), .RA_W(5)) bus ();

  alu_writeback #(.XLEN(64), .RA_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [63:0] a;
    logic [1:0]  w;
    logic        s;
    logic [63:0] exp;
  } ext_vec_t;

  typedef struct {
    logic [2:0] c;
    logic       z;
    logic       cy;
    logic       s;
    logic       exp;
  } br_vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference extension computed from the arithmetic definition
  function automatic logic [63:0] ref_ext(input logic [63:0] a, input logic [1:0] w,
                                          input logic s);
    int          bits;
    logic [63:0] mask;
    logic [63:0] v;
    bits = 8 << w;
    if (bits == 64) return a;
    mask = (64'd1 << bits) - 64'd1;
    v    = a & mask;
    if (s && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic ref_taken(input logic [2:0] c, input logic z,
                                     input logic cy, input logic s);
    logic [7:0] t;
    t = {1'b0, ~s, s, ~cy, cy, ~z, z, 1'b1};
    return t[c];
  endfunction

  task automatic clear_inputs();
    bus.in_valid  = 1'b0;
    bus.aluout    = '0;
    bus.zero      = 1'b0;
    bus.carry     = 1'b0;
    bus.setr      = 1'b0;
    bus.width     = 2'b11;
    bus.sext      = 1'b0;
    bus.wb_en     = 1'b0;
    bus.rd        = '0;
    bus.br_en     = 1'b0;
    bus.br_cond   = 3'b000;
    bus.br_target = '0;
  endtask

  task automatic check_fwd(input string name, input logic v, input logic [4:0] a,
                           input logic [63:0] d);
`ifdef WB_FORWARD_EN
    chk({name, "_fwd_valid"}, bus.fwd_valid, v);
    if (v) begin
      chk({name, "_fwd_addr"}, bus.fwd_addr, a);
      chk({name, "_fwd_data"}, bus.fwd_data, d);
    end
`else
    chk({name, "_fwd_valid"}, bus.fwd_valid, 1'b0);
    chk({name, "_fwd_addr"}, bus.fwd_addr, 5'd0);
    chk({name, "_fwd_data"}, bus.fwd_data, 64'd0);
`endif
  endtask

  // Leaves the bench at a negedge with reset released for one full cycle
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    bus.rf_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  ext_vec_t ext_tab[9];
  br_vec_t  br_tab[14];
  wr_t      pend[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        exp_redir;
    logic [63:0] exp_pc;
    logic        model_ready;
    logic        acc;
    int          n_retired;

    ext_tab[0] = '{64'h0000_0000_0000_00F0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0};
    ext_tab[1] = '{64'h0000_0000_0000_00F0, 2'b00, 1'b0, 64'h0000_0000_0000_00F0};
    ext_tab[2] = '{64'h0000_0000_1234_8001, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
    ext_tab[3] = '{64'h0000_0000_1234_8001, 2'b01, 1'b0, 64'h0000_0000_0000_8001};
    ext_tab[4] = '{64'hDEAD_BEEF_7FFF_FFFF, 2'b10, 1'b1, 64'h0000_0000_7FFF_FFFF};
    ext_tab[5] = '{64'h0000_0000_8000_0000, 2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000};
    ext_tab[6] = '{64'h8000_0000_0000_0001, 2'b11, 1'b1, 64'h8000_0000_0000_0001};
    ext_tab[7] = '{64'h8000_0000_0000_0001, 2'b11, 1'b0, 64'h8000_0000_0000_0001};
    ext_tab[8] = '{64'hFFFF_FFFF_FFFF_FF7F, 2'b00, 1'b1, 64'h0000_0000_0000_007F};

    br_tab[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[1]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b1};
    br_tab[2]  = '{3'b001, 1'b0, 1'b1, 1'b1, 1'b0};
    br_tab[3]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[4]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
    br_tab[5]  = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b1};
    br_tab[6]  = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b0};
    br_tab[7]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[8]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b0};
    br_tab[9]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b1};
    br_tab[10] = '{3'b101, 1'b1, 1'b1, 1'b0, 1'b0};
    br_tab[11] = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[12] = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b0};
    br_tab[13] = '{3'b111, 1'b1, 1'b1, 1'b1, 1'b0};

    do_reset();
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_rf_we", bus.rf_we, 1'b0);
    chk("reset_rf_waddr", bus.rf_waddr, 5'd0);
    chk("reset_rf_wdata", bus.rf_wdata, 64'd0);
    chk("reset_redirect", bus.redirect, 1'b0);
    chk("reset_redirect_pc", bus.redirect_pc, 64'd0);
    check_fwd("reset", 1'b0, 5'd0, 64'd0);

    // Extension vectors
    bus.rf_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.wb_en    = 1'b1;
      bus.rd       = 5'd3;
      bus.aluout   = ext_tab[i].a;
      bus.width    = ext_tab[i].w;
      bus.sext     = ext_tab[i].s;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("ext_rf_we", bus.rf_we, 1'b1);
      chk("ext_rf_waddr", bus.rf_waddr, 5'd3);
      chk("ext_rf_wdata", bus.rf_wdata, ext_tab[i].exp);
      $display("ext vec %0d: aluout=%h width=%0d sext=%0d -> wdata=%h",
               i, ext_tab[i].a, ext_tab[i].w, ext_tab[i].s, bus.rf_wdata);
      @(negedge clk);
    end

    // Branch condition vectors
    clear_inputs();
    for (int i = 0; i < 14; i++) begin
      bus.in_valid  = 1'b1;
      bus.br_en     = 1'b1;
      bus.br_cond   = br_tab[i].c;
      bus.zero      = br_tab[i].z;
      bus.carry     = br_tab[i].cy;
      bus.setr      = br_tab[i].s;
      bus.br_target = 64'h1000 + 64'(i * 16);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("br_redirect", bus.redirect, br_tab[i].exp);
      if (br_tab[i].exp) chk("br_redirect_pc", bus.redirect_pc, 64'h1000 + 64'(i * 16));
      $display("br vec %0d: cond=%0d z=%0d c=%0d s=%0d -> redirect=%0d pc=%h",
               i, br_tab[i].c, br_tab[i].z, br_tab[i].cy, br_tab[i].s,
               bus.redirect, bus.redirect_pc);
      @(negedge clk);
      chk("br_pulse_end", bus.redirect, 1'b0);
    end

    // Write to r0 is discarded
    clear_inputs();
    bus.in_valid = 1'b1;
    bus.wb_en    = 1'b1;
    bus.rd       = 5'd0;
    bus.aluout   = 64'h55;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("r0_rf_we", bus.rf_we, 1'b0);
    chk("r0_in_ready", bus.in_ready, 1'b1);
    $display("r0 write: rf_we=%0d in_ready=%0d", bus.rf_we, bus.in_ready);

    // Back-pressure: three writes with rf_ready low for 4 cycles
    clear_inputs();
    bus.rf_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.wb_en    = 1'b1;
    bus.rd       = 5'd1;
    bus.aluout   = 64'h11;
    @(posedge clk);
    #1;
    bus.rd     = 5'd2;
    bus.aluout = 64'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_we", bus.rf_we, 1'b1);
      chk("bp_hold_addr", bus.rf_waddr, 5'd1);
      chk("bp_hold_data", bus.rf_wdata, 64'h11);
      chk("bp_hold_ready", bus.in_ready, 1'b0);
    end
    bus.rf_ready = 1'b1;
    #1 chk("bp_release_ready", bus.in_ready, 1'b1);
    $display("bp retire: addr=%0d data=%h", bus.rf_waddr, bus.rf_wdata);
    @(posedge clk);
    #1;
    bus.rd     = 5'd3;
    bus.aluout = 64'h33;
    @(negedge clk);
    chk("bp_second_addr", bus.rf_waddr, 5'd2);
    chk("bp_second_data", bus.rf_wdata, 64'h22);
    chk("bp_second_we", bus.rf_we, 1'b1);
    $display("bp retire: addr=%0d data=%h", bus.rf_waddr, bus.rf_wdata);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third_addr", bus.rf_waddr, 5'd3);
    chk("bp_third_data", bus.rf_wdata, 64'h33);
    chk("bp_third_we", bus.rf_we, 1'b1);
    $display("bp retire: addr=%0d data=%h", bus.rf_waddr, bus.rf_wdata);
    @(negedge clk);
    chk("bp_drained_we", bus.rf_we, 1'b0);

    // Reset while FULL and stalled, with a redirect outstanding
    clear_inputs();
    bus.rf_ready  = 1'b0;
    bus.in_valid  = 1'b1;
    bus.wb_en     = 1'b1;
    bus.rd        = 5'd5;
    bus.aluout    = 64'h77;
    bus.br_en     = 1'b1;
    bus.br_cond   = 3'b000;
    bus.br_target = 64'h2000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rf_we", bus.rf_we, 1'b0);
    chk("rst_mid_redirect", bus.redirect, 1'b0);
    chk("rst_mid_fwd_valid", bus.fwd_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    chk("rst_mid_dropped", bus.rf_we, 1'b0);
    $display("reset mid-write: rf_we=%0d in_ready=%0d", bus.rf_we, bus.in_ready);

    // Forwarding of a pending write
    clear_inputs();
    bus.rf_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.wb_en    = 1'b1;
    bus.rd       = 5'd7;
    bus.aluout   = 64'hABCD;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_fwd("fwd_pending", 1'b1, 5'd7, 64'hABCD);
    end
    bus.rf_ready = 1'b1;
    #1 check_fwd("fwd_retire_cycle", 1'b1, 5'd7, 64'hABCD);
    @(negedge clk);
    check_fwd("fwd_after", 1'b0, 5'd0, 64'd0);
    $display("forward: fwd_valid=%0d", bus.fwd_valid);

    // Random traffic against a queue-based model
    do_reset();
    pend.delete();
    exp_redir = 1'b0;
    exp_pc    = '0;
    n_retired = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk("rnd_rf_we", bus.rf_we, pend.size() != 0);
      if (pend.size() != 0) begin
        chk("rnd_rf_waddr", bus.rf_waddr, pend[0].a);
        chk("rnd_rf_wdata", bus.rf_wdata, pend[0].d);
      end
      chk("rnd_redirect", bus.redirect, exp_redir);
      if (exp_redir) chk("rnd_redirect_pc", bus.redirect_pc, exp_pc);
      if (pend.size() != 0) check_fwd("rnd", 1'b1, pend[0].a, pend[0].d);
      else                  check_fwd("rnd", 1'b0, 5'd0, 64'd0);

      bus.in_valid  = ($urandom % 4) != 0;
      bus.aluout    = {$urandom, $urandom};
      bus.width     = 2'($urandom % 4);
      bus.sext      = 1'($urandom % 2);
      bus.wb_en     = ($urandom % 4) != 0;
      bus.rd        = 5'($urandom_range(0, 7));
      bus.br_en     = 1'($urandom % 2);
      bus.br_cond   = 3'($urandom % 8);
      bus.zero      = 1'($urandom % 2);
      bus.carry     = 1'($urandom % 2);
      bus.setr      = 1'($urandom % 2);
      bus.br_target = {$urandom, $urandom};
      bus.rf_ready  = ($urandom % 3) != 0;
      #1;
      model_ready = (pend.size() == 0) || bus.rf_ready;
      chk("rnd_in_ready", bus.in_ready, model_ready);
      acc = bus.in_valid && model_ready;
      @(posedge clk);
      exp_redir = acc && bus.br_en && ref_taken(bus.br_cond, bus.zero, bus.carry, bus.setr);
      exp_pc    = bus.br_target;
      if (pend.size() != 0 && bus.rf_ready) begin
        $display("rnd retire: addr=%0d data=%h", pend[0].a, pend[0].d);
        void'(pend.pop_front());
        n_retired++;
      end
      if (acc && bus.wb_en && bus.rd != 5'd0)
        pend.push_back('{bus.rd, ref_ext(bus.aluout, bus.width, bus.sext)});
      @(negedge clk);
    end
    $display("random phase: %0d writes retired", n_retired);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-to-writeback stage directly downstream of the ALU interface.
- Accepts one ALU result per handshake, together with the registered zero/carry/setr flags, destination register and branch control.
- Width-masks and extends the result, then writes it to the register-file write port through a valid/ready handshake.
- Resolves conditional branches from the flags and issues a one-cycle PC redirect pulse.

Parameters:
- XLEN, 64, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept a result
- aluout  in  XLEN  ALU result
- zero  in  1  registered zero flag
- carry  in  1  registered carry flag
- setr  in  1  ALU set-result flag
- width  in  2  00=8b, 01=16b, 10=32b, 11=64b
- sext  in  1  1=sign-extend, 0=zero-extend
- wb_en  in  1  op writes a register
- rd  in  RA_W  destination register
- br_en  in  1  op is a branch
- br_cond  in  3  condition code
- br_target  in  XLEN  branch target
- rf_we  out  1  register-file write request (valid)
- rf_ready  in  1  write port granted this cycle
- rf_waddr  out  RA_W  write address
- rf_wdata  out  XLEN  write data
- redirect  out  1  one-cycle taken-branch pulse
- redirect_pc  out  XLEN  new PC
- fwd_valid  out  1  bypass entry valid
- fwd_addr  out  RA_W  bypass register
- fwd_data  out  XLEN  bypass data

Behaviour:
- Reset: state EMPTY; all outputs 0, except in_ready=1 from the first cycle after reset. Reset asserted mid-operation drops any held write with no write-back.
- Accept condition: in_valid && in_ready. All inputs are sampled only on the accept edge.
- Extension:
  - result = aluout[w-1:0] for w = 8/16/32/64.
  - Upper bits = replicated bit w-1 when sext=1, else 0.
  - width=11 passes aluout through unchanged.
- Write path. A write is "effective" when wb_en=1 and rd!=0; writes to r0 are discarded.
- States:
  - EMPTY:
    - in_ready=1.
    - On accept with an effective write: go to FULL, latch rd and the extended result into the output register, assert rf_we from the next cycle.
  - FULL:
    - rf_we=1, holding rf_waddr and rf_wdata stable until rf_ready.
    - in_ready = rf_ready, so a new result is accepted in the same cycle the held write retires.
    - On rf_ready with a simultaneous accept of an effective write: stay FULL with the new entry.
    - On rf_ready with no new effective write: go to EMPTY.
    - rf_ready while EMPTY is ignored.
- Branch conditions, evaluated on the accept edge:
  - 000 always; 001 zero; 010 !zero; 011 carry; 100 !carry; 101 setr; 110 !setr; 111 never.
  - If br_en=1 and the condition is true: redirect=1 for exactly the next cycle with redirect_pc=br_target.
  - Redirect is independent of write-path state; a branch with wb_en=1 (link) does both.
- Ordering: writes retire in acceptance order. Latency from accept to first rf_we is 1 cycle.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined:
  - fwd_valid/fwd_addr/fwd_data mirror the FULL entry (fwd_valid = state==FULL).
  - Through the cycle rf_ready retires the entry, downstream operand fetch can bypass a pending write.
- Undefined: fwd_valid, fwd_addr and fwd_data are tied to 0, with no extra logic.

Decomposition:
- Shared package t64_wb_pkg holds:
  - width_t enum (W8, W16, W32, W64).
  - br_cond_t enum (the eight codes above).
  - wb_state_t (EMPTY, FULL).
- One natural sub-module: wb_extend, a combinational width mask and sign/zero extender, reusable by the load unit.

Test Plan:
- Extension: aluout=64'h0000_0000_0000_00F0, width=00, sext=1, wb_en=1, rd=3, rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=64'hFFFF_FFFF_FFFF_FFF0. With sext=0 -> 64'hF0.
- Back-pressure: three back-to-back results rd=1,2,3 with rf_ready low for 4 cycles -> first entry held stable, in_ready=0. On release, writes retire in order 1,2,3 with no loss or duplication.
- r0 write: wb_en=1, rd=0 -> rf_we stays 0 and in_ready stays 1.
- Branch: br_en=1, br_cond=001, zero=1, br_target=64'h1000 -> redirect=1 for exactly one cycle with redirect_pc=64'h1000. Same with zero=0 -> redirect stays 0. Repeat for carry/setr codes.
- Reset mid-write: reset asserted while FULL with rf_ready=0 -> the following cycle shows rf_we=0, redirect=0, fwd_valid=0; in_ready=1 one cycle after reset deasserts.
- Forwarding (WB_FORWARD_EN): pending write rd=7, data 64'hABCD -> fwd_valid=1, fwd_addr=7, fwd_data=64'hABCD until retire. Without the macro, all three read 0.
